// File: rtl/r_backward_arbiter.sv
// r_backward_arbiter: merges AXI4 R beats from four slave ports onto one
// master port. Round-robin, burst-locked arbitration (a granted port keeps
// the output until its RLAST beat is accepted) feeding a one-entry
// registered output stage.
//
// Optional feature: define R_BACKWARD_WATCHDOG_EN to compile in a stall
// watchdog that releases a lock held by a silent port after TIMEOUT cycles
// and pulses ERRo for one cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; next port picked from valid inputs in ptr order
// LOCK  | port g owns the output until its RLAST beat is accepted

module r_backward_arbiter #(
  parameter int W       = 77,
  parameter int TIMEOUT = 255
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [W-1:0] DATA0i,
  input  logic [W-1:0] DATA1i,
  input  logic [W-1:0] DATA2i,
  input  logic [W-1:0] DATA3i,
  input  logic         VALID0i,
  input  logic         VALID1i,
  input  logic         VALID2i,
  input  logic         VALID3i,
  output logic         READY0i,
  output logic         READY1i,
  output logic         READY2i,
  output logic         READY3i,
  output logic [W-1:0] DATAo,
  output logic         VALIDo,
  input  logic         READYo,
  output logic         ERRo
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("r_backward_arbiter: TIMEOUT out of range 1..65535");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t       state;
  logic [1:0]   g;
  logic [1:0]   ptr;

  logic [W-1:0] data_in [4];
  logic [3:0]   valid_in;
  logic [3:0]   ready_vec;
  logic         slot_free;
  logic         xfer;
  logic         beat_last;
  logic [1:0]   win;
  logic [1:0]   cand;
  logic         any_valid;
  logic         timeout_hit;

  assign data_in[0] = DATA0i;
  assign data_in[1] = DATA1i;
  assign data_in[2] = DATA2i;
  assign data_in[3] = DATA3i;
  assign valid_in   = {VALID3i, VALID2i, VALID1i, VALID0i};
  assign {READY3i, READY2i, READY1i, READY0i} = ready_vec;

  // The output register can take a beat when empty or draining this cycle.
  assign slot_free = ~VALIDo | READYo;
  assign xfer      = (state == LOCK) & valid_in[g] & slot_free;
  assign beat_last = data_in[g][0];

  // Only the locked port sees ready, and only while the slot is free.
  always_comb begin
    ready_vec = '0;
    if (state == LOCK && slot_free) ready_vec[g] = 1'b1;
  end

  // First valid port searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    win       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!any_valid && valid_in[cand]) begin
        win       = cand;
        any_valid = 1'b1;
      end
    end
  end

`ifdef R_BACKWARD_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  // A transfer in the same cycle wins over the timeout.
  assign timeout_hit = (state == LOCK) & ~xfer & (wd_cnt == 16'(TIMEOUT));
  assign ERRo        = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ERRo        = 1'b0;
`endif

  // Grant FSM, round-robin pointer, output stage and optional watchdog.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      g      <= '0;
      ptr    <= '0;
      DATAo  <= '0;
      VALIDo <= 1'b0;
`ifdef R_BACKWARD_WATCHDOG_EN
      wd_cnt <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
`ifdef R_BACKWARD_WATCHDOG_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_valid) begin
            g     <= win;
            state <= LOCK;
`ifdef R_BACKWARD_WATCHDOG_EN
            wd_cnt <= '0;
`endif
          end
        end
        LOCK: begin
          if (timeout_hit) begin
            state <= IDLE;
            ptr   <= g + 2'd1;
`ifdef R_BACKWARD_WATCHDOG_EN
            err_q  <= 1'b1;
            wd_cnt <= '0;
`endif
          end else if (xfer && beat_last) begin
            state <= IDLE;
            ptr   <= g + 2'd1;
          end
`ifdef R_BACKWARD_WATCHDOG_EN
          // Only silent cycles count; backpressured cycles hold the count.
          if (xfer) wd_cnt <= '0;
          else if (!valid_in[g] && !timeout_hit) wd_cnt <= wd_cnt + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        DATAo  <= data_in[g];
        VALIDo <= 1'b1;
      end else if (READYo) begin
        VALIDo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_r_backward_arbiter.sv
`timescale 1ns/1ps

module tb_r_backward_arbiter;

  localparam int W  = 77;
  localparam int TO = 10;

  logic         ACLK    = 1'b0;
  logic         ARESETn = 1'b1;
  logic [W-1:0] data_i [4];
  logic [3:0]   valid_i;
  wire  [3:0]   ready_i;
  logic [W-1:0] DATAo;
  logic         VALIDo;
  logic         READYo;
  logic         ERRo;

  always #5 ACLK = ~ACLK;

  r_backward_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .DATA0i(data_i[0]), .DATA1i(data_i[1]), .DATA2i(data_i[2]), .DATA3i(data_i[3]),
    .VALID0i(valid_i[0]), .VALID1i(valid_i[1]), .VALID2i(valid_i[2]), .VALID3i(valid_i[3]),
    .READY0i(ready_i[0]), .READY1i(ready_i[1]), .READY2i(ready_i[2]), .READY3i(ready_i[3]),
    .DATAo(DATAo), .VALIDo(VALIDo), .READYo(READYo), .ERRo(ERRo)
  );

  // Stimulus side: beats still to be offered on each port.
  logic [W-1:0] port_q [4][$];
  int           sent [4];
  int           stall_after [4];
  logic [3:0]   took;
  logic         last_rlast;
  bit           ready_mode;
  int           hold_lo;

  // Reference model: per-port bursts and the expected merged stream.
  logic [W-1:0] mq [4][$];
  int           mlen [4][$];
  int           mptr;
  logic [W-1:0] sb_q [$];

  int checks = 0;
  int passes = 0;

  task automatic check(input logic [W-1:0] act, input logic [W-1:0] exp, input string name);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rand_beat(input bit last);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {r[W-1:1], last};
  endfunction

  task automatic load_burst(input int k, input int len);
    logic [W-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      port_q[k].push_back(b);
      mq[k].push_back(b);
    end
    mlen[k].push_back(len);
  endtask

  // All loaded bursts are offered at once; whole bursts are served in
  // round-robin order starting at mptr, skipping ports with nothing left.
  task automatic plan();
    int p, len;
    while (1) begin
      p = -1;
      for (int i = 0; i < 4; i++)
        if (p < 0 && mlen[(mptr + i) % 4].size() > 0) p = (mptr + i) % 4;
      if (p < 0) break;
      len = mlen[p].pop_front();
      repeat (len) sb_q.push_back(mq[p].pop_front());
      mptr = (p + 1) % 4;
    end
  endtask

  task automatic cycle();
    @(negedge ACLK);
    for (int k = 0; k < 4; k++)
      if (took[k]) begin
        void'(port_q[k].pop_front());
        sent[k]++;
      end
    for (int k = 0; k < 4; k++) begin
      valid_i[k] = (port_q[k].size() > 0) && (sent[k] != stall_after[k]);
      data_i[k]  = (port_q[k].size() > 0) ? port_q[k][0] : '0;
    end
    if (hold_lo > 0) begin
      READYo = 1'b0;
      hold_lo--;
    end else if (ready_mode) READYo = 1'b1;
    else READYo = ($urandom_range(3) != 0);
    #4;
    took = valid_i & ready_i;
    if (last_rlast) check(W'(took), '0, "input_gap_after_rlast");
    last_rlast = 1'b0;
    for (int k = 0; k < 4; k++)
      if (took[k] && data_i[k][0]) last_rlast = 1'b1;
  endtask

  function automatic bit busy();
    bit b;
    b = (sb_q.size() > 0) || VALIDo;
    for (int k = 0; k < 4; k++) if (port_q[k].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n < budget) passes++;
    else $display("FAIL drain_%s got timeout after %0d cycles expected empty", name, n);
  endtask

  task automatic apply_reset();
    @(posedge ACLK);
    #2;
    ARESETn = 1'b0;
    valid_i = '0;
    #1;
    check(W'(VALIDo), '0, "rst_valido");
    check(DATAo, '0, "rst_datao");
    check(W'(ERRo), '0, "rst_erro");
    check(W'(ready_i), '0, "rst_ready");
    for (int k = 0; k < 4; k++) begin
      port_q[k].delete();
      mq[k].delete();
      mlen[k].delete();
      stall_after[k] = -1;
    end
    sb_q.delete();
    took       = '0;
    last_rlast = 1'b0;
    hold_lo    = 0;
    mptr       = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // Monitor: pops the expected stream on every output handshake and checks
  // that a stalled output stays put.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge ACLK) begin
    #4;
    if (!ARESETn) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check(W'(VALIDo), W'(1), "stall_valido");
        check(DATAo, prev_data, "stall_datao");
      end
      if (VALIDo && !READYo) check(W'(ready_i), '0, "stall_ready");
      if (VALIDo && READYo) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL beat got %h expected none", DATAo);
        end else check(DATAo, sb_q.pop_front(), "beat");
      end
      prev_hold = VALIDo && !READYo;
      prev_data = DATAo;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, n, s, errs, err_cyc, r2;
    valid_i = '0;
    READYo  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_i[k]      = '0;
      sent[k]        = 0;
      stall_after[k] = -1;
    end
    took       = '0;
    last_rlast = 1'b0;
    ready_mode = 1'b1;
    hold_lo    = 0;
    mptr       = 0;

    // Single port: 4-beat burst on port 2, VALIDo on cycles 2..5.
    apply_reset();
    load_burst(2, 4);
    plan();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check(W'(VALIDo), W'(i >= 2 && i <= 5), $sformatf("single_valido_c%0d", i));
    end
    drain("single", 50);
    // ptr is now 3: port 3 must beat port 0.
    load_burst(0, 1);
    load_burst(3, 1);
    plan();
    drain("ptr3", 50);

    // Contention from reset: ports 0, 1, 3.
    apply_reset();
    load_burst(0, 2);
    load_burst(1, 2);
    load_burst(3, 2);
    plan();
    drain("contention", 100);

    // Backpressure mid-burst.
    load_burst(1, 6);
    plan();
    repeat (4) cycle();
    hold_lo = 5;
    drain("backpressure", 100);

    // Reset mid-burst with ptr left at 3 beforehand.
    load_burst(2, 1);
    plan();
    drain("pre_reset", 50);
    base = sent[2];
    load_burst(2, 8);
    plan();
    n = 0;
    while (sent[2] < base + 2 && n < 50) begin
      cycle();
      n++;
    end
    check(W'(n < 50), W'(1), "midburst_progress");
    apply_reset();
    load_burst(1, 1);
    load_burst(3, 1);
    plan();
    drain("post_reset", 50);

    // Back-to-back on port 0 with port 1 waiting.
    load_burst(0, 1);
    load_burst(0, 1);
    load_burst(1, 1);
    plan();
    drain("back_to_back", 50);

    // Port 1 stalls mid-burst while port 2 waits.
    base = sent[1];
    load_burst(1, 4);
    load_burst(2, 1);
`ifdef R_BACKWARD_WATCHDOG_EN
    sb_q.push_back(mq[1][0]);
    sb_q.push_back(mq[1][1]);
`else
    for (int i = 0; i < 4; i++) sb_q.push_back(mq[1][i]);
`endif
    sb_q.push_back(mq[2][0]);
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mlen[k].delete();
    end
    mptr = 3;
    stall_after[1] = base + 2;
    s = -1;
    errs = 0;
    err_cyc = -1;
    r2 = 0;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (s < 0 && sent[1] == base + 2) s = c;
      if (ERRo) begin
        errs++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (ready_i[2] && err_cyc < 0) r2++;
    end
`ifdef R_BACKWARD_WATCHDOG_EN
    check(W'(errs), W'(1), "wd_err_pulses");
    check(W'(s >= 0 && (err_cyc == s + TO || err_cyc == s + TO + 1)), W'(1), "wd_err_timing");
    check(W'(r2), '0, "wd_port2_before_err");
    port_q[1].delete();
`else
    check(W'(errs), '0, "nowd_erro");
    check(W'(r2), '0, "nowd_lock_held");
`endif
    stall_after[1] = -1;
    drain("stall", 100);

    // Randomized rounds with random READYo.
    ready_mode = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(0, 3);
        repeat (n) load_burst(k, $urandom_range(1, 5));
      end
      plan();
      drain($sformatf("random%0d", r), 3000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
